// File: rtl/dcache_uncached_bridge.sv
// Uncached data-cache bridge: turns one CPU load/store request at a time into
// single-beat AXI-style read or write bus transactions.
module dcache_uncached_bridge (
    input  logic        clk,
    input  logic        rst,
    // CPU request/response
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    // bus read
    output logic        arvalid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    input  logic        arready,
    input  logic        rvalid,
    input  logic [31:0] rdata_i,
    output logic        rready,
    // bus write
    output logic        awvalid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    input  logic        awready,
    output logic        wvalid,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AWW,
        S_B,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                data_ok_q, data_ok_d;
    logic                addr_ok_c;

    // State, request latch and registered bus controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            data_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            data_ok_q <= data_ok_d;
        end
    end

    // Next state; bus controls are decoded from the next state so they are flops
    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_ok_c = req && (state_q == S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (addr_ok_c) begin
                    size_d    = size;
                    addr_d    = addr;
                    wdata_d   = wdata;
                    wstrb_d   = wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = wr ? S_AWW : S_AR;
                end
            end
            S_AR: begin
                if (arvalid_q && arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (rvalid) begin
                    rdata_d = rdata_i;
                    state_d = S_DONE;
                end
            end
            S_AWW: begin
                if (awvalid_q && awready) begin
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && wready) begin
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = S_B;
                end
            end
            S_B: begin
                if (bvalid) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        arvalid_d = (state_d == S_AR);
        rready_d  = (state_d == S_R);
        awvalid_d = (state_d == S_AWW) && !aw_done_d;
        wvalid_d  = (state_d == S_AWW) && !w_done_d;
        bready_d  = (state_d == S_B);
        data_ok_d = (state_d == S_DONE);
    end

    assign addr_ok = addr_ok_c;
    assign data_ok = data_ok_q;
    assign rdata   = rdata_q;

    assign arvalid = arvalid_q;
    assign araddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign rready  = rready_q;

    assign awvalid = awvalid_q;
    assign awaddr  = addr_q;
    assign awsize  = {1'b0, size_q};
    assign wvalid  = wvalid_q;
    assign wdata_o = wdata_q;
    assign wstrb_o = wstrb_q;
    assign wlast   = wvalid_q;
    assign bready  = bready_q;

endmodule

// File: tb/tb_dcache_uncached_bridge.sv
// Self-checking bench for dcache_uncached_bridge: directed bus timing checks
// plus an in-order scoreboard that matches every data_ok against its request.
module tb_dcache_uncached_bridge;

    logic        clk;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        arvalid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata_i;
    logic        rready;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awready;
    logic        wvalid;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        wlast;
    logic        wready;
    logic        bvalid;
    logic        bready;

    dcache_uncached_bridge dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata),
        .arvalid (arvalid),
        .araddr  (araddr),
        .arsize  (arsize),
        .arready (arready),
        .rvalid  (rvalid),
        .rdata_i (rdata_i),
        .rready  (rready),
        .awvalid (awvalid),
        .awaddr  (awaddr),
        .awsize  (awsize),
        .awready (awready),
        .wvalid  (wvalid),
        .wdata_o (wdata_o),
        .wstrb_o (wstrb_o),
        .wlast   (wlast),
        .wready  (wready),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    typedef struct packed {
        logic        is_load;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cycle    = 0;
    int   a1, a2, d1, d2, dok_cnt, phase;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        arready = 1'b0;
        rvalid  = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
    endtask

    // Scoreboard: every completion pops the oldest accepted request
    always @(negedge clk) begin
        if (!rst && data_ok) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_data_ok", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.is_load) check_eq("sb_load_rdata", rdata, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; wdata = '0; wstrb = '0;
        rdata_i = '0;
        idle_bus();

        // Reset values hold before any clock edge
        #2;
        check_eq("rst_ctrl", 32'({arvalid, rready, awvalid, wvalid, wlast, bready, data_ok}), 32'd0);
        check_eq("rst_rdata", rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Zero-wait load; first request after reset
        req = 1'b1; wr = 1'b0; addr = 32'hBFC0_0010; size = 2'd2;
        arready = 1'b1; rvalid = 1'b1; rdata_i = 32'h1234_5678;
        #1 check_eq("ld_addr_ok_T", 32'(addr_ok), 32'd1);
        sb.push_back('{is_load: 1'b1, data: 32'h1234_5678});
        cyc(); req = 1'b0;
        #1 check_eq("ld_arvalid_T1", 32'(arvalid), 32'd1);
        check_eq("ld_araddr_T1", araddr, 32'hBFC0_0010);
        check_eq("ld_arsize_T1", 32'(arsize), 32'd2);
        check_eq("ld_data_ok_T1", 32'(data_ok), 32'd0);
        cyc();
        #1 check_eq("ld_rready_T2", 32'(rready), 32'd1);
        check_eq("ld_data_ok_T2", 32'(data_ok), 32'd0);
        cyc();
        #1 check_eq("ld_data_ok_T3", 32'(data_ok), 32'd1);
        check_eq("ld_rdata_T3", rdata, 32'h1234_5678);
        cyc();
        #1 check_eq("ld_data_ok_T4", 32'(data_ok), 32'd0);
        idle_bus();

        // Store with split address/data handshakes
        req = 1'b1; wr = 1'b1; addr = 32'h1FAF_0000; size = 2'd1;
        wdata = 32'hDEAD_BEEF; wstrb = 4'b0011;
        #1 check_eq("st_addr_ok_T", 32'(addr_ok), 32'd1);
        sb.push_back('{is_load: 1'b0, data: 32'h0});
        cyc(); req = 1'b0; awready = 1'b1;
        #1 check_eq("st_valids_T1", 32'({awvalid, wvalid, wlast}), 32'b111);
        check_eq("st_awaddr", awaddr, 32'h1FAF_0000);
        check_eq("st_awsize", 32'(awsize), 32'd1);
        check_eq("st_wdata", wdata_o, 32'hDEAD_BEEF);
        check_eq("st_wstrb", 32'(wstrb_o), 32'b0011);
        cyc(); awready = 1'b0;
        #1 check_eq("st_valids_T2", 32'({awvalid, wvalid, wlast}), 32'b011);
        cyc(); wready = 1'b1;
        #1 check_eq("st_valids_T3", 32'({awvalid, wvalid, wlast, bready}), 32'b0110);
        cyc(); wready = 1'b0;
        #1 check_eq("st_bready_T4", 32'({awvalid, wvalid, bready}), 32'b001);
        cyc(); bvalid = 1'b1;
        #1 check_eq("st_data_ok_T5", 32'(data_ok), 32'd0);
        cyc(); bvalid = 1'b0;
        #1 check_eq("st_data_ok_T6", 32'(data_ok), 32'd1);
        cyc();
        #1 check_eq("st_data_ok_T7", 32'(data_ok), 32'd0);

        // Read-address backpressure with a second request waiting
        req = 1'b1; wr = 1'b0; addr = 32'h8000_0040; size = 2'd2;
        #1 check_eq("bp_addr_ok_T", 32'(addr_ok), 32'd1);
        sb.push_back('{is_load: 1'b1, data: 32'h5555_AAAA});
        for (int k = 1; k <= 5; k++) begin
            cyc();
            wr = 1'b1; addr = 32'h0000_0F00; wdata = 32'h0102_0304; wstrb = 4'hF; size = 2'd2;
            #1 check_eq("bp_arvalid", 32'(arvalid), 32'd1);
            check_eq("bp_araddr", araddr, 32'h8000_0040);
            check_eq("bp_addr_ok_busy", 32'(addr_ok), 32'd0);
        end
        cyc(); arready = 1'b1;
        #1 check_eq("bp_arvalid_hs", 32'(arvalid), 32'd1);
        cyc(); arready = 1'b0; rvalid = 1'b1; rdata_i = 32'h5555_AAAA;
        #1 check_eq("bp_rready", 32'({arvalid, rready, addr_ok}), 32'b010);
        cyc(); rvalid = 1'b0;
        #1 check_eq("bp_data_ok", 32'({data_ok, addr_ok}), 32'b10);
        cyc();
        #1 check_eq("bp_second_addr_ok", 32'(addr_ok), 32'd1);
        sb.push_back('{is_load: 1'b0, data: 32'h0});
        awready = 1'b1; wready = 1'b1;
        cyc(); req = 1'b0;
        #1 check_eq("bp_st_valids", 32'({awvalid, wvalid}), 32'b11);
        cyc(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        #1 check_eq("bp_st_bready", 32'(bready), 32'd1);
        cyc(); bvalid = 1'b0;
        #1 check_eq("bp_st_data_ok", 32'(data_ok), 32'd1);
        cyc();

        // Back-to-back load then store against an always-ready bus
        arready = 1'b1; rvalid = 1'b1; awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        rdata_i = 32'hCAFE_0001;
        req = 1'b1; wr = 1'b0; addr = 32'h0000_1000; size = 2'd2; wdata = '0; wstrb = '0;
        a1 = -1; a2 = -1; d1 = -1; d2 = -1; dok_cnt = 0; phase = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (data_ok) begin
                dok_cnt++;
                if (d1 < 0) d1 = cycle; else d2 = cycle;
            end
            if (addr_ok) begin
                if (phase == 0) begin
                    a1 = cycle;
                    sb.push_back('{is_load: 1'b1, data: 32'hCAFE_0001});
                    phase = 1;
                end else begin
                    a2 = cycle;
                    sb.push_back('{is_load: 1'b0, data: 32'h0});
                    phase = 2;
                end
            end
            cyc();
            if (phase == 1) begin
                wr = 1'b1; addr = 32'h0000_2004; wdata = 32'h7777_8888; wstrb = 4'b1100;
            end else if (phase == 2) begin
                req = 1'b0;
            end
        end
        check_eq("b2b_dok_count", 32'(dok_cnt), 32'd2);
        check_eq("b2b_load_latency", 32'(d1 - a1), 32'd3);
        check_eq("b2b_second_addr_ok", 32'(a2 - d1), 32'd1);
        check_eq("b2b_store_latency", 32'(d2 - a2), 32'd3);
        idle_bus();
        req = 1'b0;
        cyc();

        // Reset asserted while waiting in R
        req = 1'b1; wr = 1'b0; addr = 32'h0000_3000; size = 2'd2; arready = 1'b1;
        #1 check_eq("rm_addr_ok", 32'(addr_ok), 32'd1);
        cyc(); req = 1'b0;
        #1 check_eq("rm_arvalid", 32'(arvalid), 32'd1);
        cyc(); arready = 1'b0;
        #1 check_eq("rm_rready_before", 32'(rready), 32'd1);
        rst = 1'b1;
        #1 check_eq("rm_ctrl_in_rst", 32'({arvalid, rready, awvalid, wvalid, wlast, bready, data_ok}), 32'd0);
        check_eq("rm_rdata_in_rst", rdata, 32'h0);
        cyc(); rst = 1'b0; rvalid = 1'b1; rdata_i = 32'hDEAD_0000;
        #1 check_eq("rm_stale_rvalid", 32'({rready, data_ok}), 32'b00);
        cyc();
        #1 check_eq("rm_no_data_ok", 32'(data_ok), 32'd0);
        rvalid = 1'b0;
        req = 1'b1; wr = 1'b0; addr = 32'h0000_4000; arready = 1'b1;
        #1 check_eq("rm_next_addr_ok", 32'(addr_ok), 32'd1);
        sb.push_back('{is_load: 1'b1, data: 32'h0BAD_F00D});
        cyc(); req = 1'b0;
        cyc(); arready = 1'b0; rvalid = 1'b1; rdata_i = 32'h0BAD_F00D;
        #1 check_eq("rm_next_rready", 32'(rready), 32'd1);
        cyc(); rvalid = 1'b0;
        #1 check_eq("rm_next_data_ok", 32'(data_ok), 32'd1);
        check_eq("rm_next_rdata", rdata, 32'h0BAD_F00D);
        cyc();
        cyc();
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
